qspi_ram_target: RTL and testbench
==================================

Name: qspi_ram_target

Overview:
- Synthesizable QSPI RAM responder: the target end of the quad-SPI link driven by the CPU-side QSPI controller.
- Oversamples SCK, CS and IO[3:0] on the system clock.
- Decodes quad-mode read and write commands and serves a small internal byte array.
- Used as an on-chip RAM stand-in for simulation, FPGA bring-up and loopback self-test of the memory path.

Parameters:
- DEPTH, 256, number of bytes in the internal array; must be a power of two.
- DUMMY_CYCLES, 6, SCK cycles between the last address nibble and the first read data nibble.
- ADDR_BITS, 24, address bits received on the wire; only the low log2(DEPTH) bits index the array.

Ports:
- clock  input  1  system clock; at least 4x the SCK frequency.
- reset  input  1  asynchronous, active-low reset.
- spi_clk_in  input  1  SCK from the initiator; mode 0, idles low.
- spi_select_n  input  1  chip select, active-low.
- spi_data_in  input  4  IO[3:0] from the initiator.
- spi_data_out  output  4  IO[3:0] driven to the initiator.
- spi_data_oe  output  4  per-bit output enable; all-ones while driving read data.
- active  output  1  high while a recognised command is in progress.
- cmd_error  output  1  one-clock pulse when an unknown command byte completes.

Behaviour:
- Reset (async assert, sync release): state IDLE; spi_data_out=0, spi_data_oe=0, active=0, cmd_error=0; address register 0.
- Array contents are not reset.
- Synchronisers: 2-flop sync on spi_clk_in, spi_select_n and spi_data_in.
  - Rise/fall edges are detected from the synced SCK.
  - Data is sampled on the synced rise using the synced IO value of the same cycle.
- Framing: all phases are quad, MSB nibble first, 2 nibbles per byte.
- Synced select high forces IDLE from any state within 3 clocks: oe=0, active=0, partial byte discarded.
- A select falling edge enters CMD with the nibble counter cleared.
- States and transitions:
  - IDLE: wait for select low, then go to CMD.
  - CMD: 2 rising edges assemble the command byte.
    - 0xEB goes to ADDR with read flag set.
    - 0x38 goes to ADDR with write flag set.
    - Any other byte pulses cmd_error for 1 clock and goes to IGNORE.
  - ADDR: 6 rising edges assemble the 24-bit address (ADDR_BITS/4 nibbles).
    - Read goes to DUMMY; write goes to WR_DATA.
  - DUMMY: count DUMMY_CYCLES rising edges.
    - On the last one, preload the data byte at addr and go to RD_DATA.
    - If DUMMY_CYCLES=0, preload at the end of ADDR instead.
  - RD_DATA: oe=4'hF.
    - Drive the high nibble after the first SCK fall following entry; drive the low nibble on the next fall.
    - After the low nibble's rising edge, addr increments and the next byte is fetched before the next fall.
    - Output changes at most 3 clocks after an SCK fall.
  - WR_DATA: oe=0.
    - The high nibble is captured on one rise, the low nibble on the next.
    - The array write happens in the clock after the low-nibble rise; then addr increments.
  - IGNORE: oe=0; wait for select high.
- active=1 in ADDR, DUMMY, RD_DATA and WR_DATA; 0 otherwise.
- Address wrap: index = addr mod DEPTH, and increments wrap modulo DEPTH.
  - Example: DEPTH=256, start at 0xFF, a 2-byte burst accesses 0xFF then 0x00.
- Bursts have unbounded length and continue until select goes high.
- Select high mid-write after one nibble: that byte is not written; previously completed bytes are kept.
- Select re-asserted within the same clock as it deasserts is not possible (sync depth); a new frame needs 2 clocks of select high.
- SCK edges while select is high are ignored.

Decomposition:
- Shared package qspi_pkg:
  - qspi_target_state_e enum (IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE).
  - Constants QSPI_CMD_QUAD_READ=8'hEB and QSPI_CMD_QUAD_WRITE=8'h38.
  - Constant QSPI_ADDR_NIBBLES=6.
- Sub-module qspi_sync_edge: 2-flop synchroniser plus rise/fall detector; instanced for SCK and select; a plain sync for IO.

Test Plan:
- Reset mid-RD_DATA (reset=0 for 2 clocks) -> oe=0, out=0, active=0 immediately; next frame decodes normally.
- Write 0x38, addr 0x000010, data A5 3C; then read 0xEB, addr 0x000010, 6 dummy -> nibbles A,5,3,C returned; oe=F only in RD_DATA.
- Wrap: write 0x11 at 0xFF and 0x22 at 0x00, then read 3 bytes from 0xFF -> 11, 22, then the byte at 0x01.
- Unknown command 0x9F -> cmd_error pulses once, oe stays 0 for the whole frame, array unchanged.
- Write to 0x20, select deasserted after 3 nibbles (1.5 bytes) -> byte 0x20 updated, byte 0x21 unchanged.
- SCK at clock/4 with back-to-back frames separated by 2 clocks of select high -> both frames decoded correctly.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI RAM target.
//   qspi_target_state_e : frame decoder states
//   QSPI_CMD_QUAD_READ  : quad read command byte (0xEB)
//   QSPI_CMD_QUAD_WRITE : quad write command byte (0x38)
//   QSPI_ADDR_NIBBLES   : address nibbles for a 24-bit address
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    DUMMY   = 3'd3,
    RD_DATA = 3'd4,
    WR_DATA = 3'd5,
    IGNORE  = 3'd6
  } qspi_target_state_e;

  localparam logic [7:0] QSPI_CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] QSPI_CMD_QUAD_WRITE = 8'h38;
  localparam int         QSPI_ADDR_NIBBLES   = 6;

endpackage

// File: rtl/qspi_ram_target_if.sv
// Quad-SPI pin bundle between an initiator and the RAM target.
//   spi_clk_in   : SCK, mode 0 (idles low)
//   spi_select_n : chip select, active-low
//   spi_data_in  : IO[3:0] driven by the initiator
//   spi_data_out : IO[3:0] driven by the target
//   spi_data_oe  : per-bit target output enable
//   active       : target is inside a recognised command
//   cmd_error    : one-clock pulse on an unknown command byte
interface qspi_ram_target_if;

  logic       spi_clk_in;
  logic       spi_select_n;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  logic       active;
  logic       cmd_error;

  modport master (
    output spi_clk_in, spi_select_n, spi_data_in,
    input  spi_data_out, spi_data_oe, active, cmd_error
  );

  modport slave (
    input  spi_clk_in, spi_select_n, spi_data_in,
    output spi_data_out, spi_data_oe, active, cmd_error
  );

endinterface

// File: rtl/qspi_sync_edge.sv
// Two-flop synchroniser with rise/fall detection on the synchronised level.
//   i_clock   : system clock
//   i_reset_n : asynchronous active-low reset
//   i_async   : asynchronous input
//   o_rise    : one-clock pulse on a synchronised 0->1 transition
//   o_fall    : one-clock pulse on a synchronised 1->0 transition
// RST_VAL is the idle level of the input so that reset release with the
// input at rest produces no spurious edge.
module qspi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/qspi_ram_target.sv
// QSPI RAM responder: oversamples the quad-SPI pins on the system clock,
// decodes quad read (0xEB) and quad write (0x38) and serves a byte array.
//   clock : system clock, at least 4x SCK
//   reset : asynchronous active-low reset
//   bus   : QSPI pin bundle (slave modport)
module qspi_ram_target
  import qspi_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int DUMMY_CYCLES = 6,
  parameter int ADDR_BITS    = 24
) (
  input  logic             clock,
  input  logic             reset,
  qspi_ram_target_if.slave bus
);

  localparam int         IDX_BITS       = $clog2(DEPTH);
  localparam int         ADDR_NIB       = ADDR_BITS / 4;
  localparam logic [7:0] LAST_ADDR_CNT  = 8'(ADDR_NIB - 1);
  localparam logic [7:0] LAST_DUMMY_CNT = 8'(DUMMY_CYCLES - 1);

  logic [7:0]          r_mem [DEPTH];
  qspi_target_state_e  r_state;
  logic [IDX_BITS-1:0] r_addr;
  logic [7:0]          r_cnt;
  logic                r_nib;       // 0: next nibble is the high one
  logic                r_rd_mode;
  logic [3:0]          r_hi;
  logic [7:0]          r_rd_byte;
  logic [7:0]          r_wr_byte;
  logic                r_wr_pend;
  logic [3:0]          r_io_meta;
  logic [3:0]          r_io_sync;
  logic [3:0]          r_out;
  logic [3:0]          r_oe;
  logic                r_active;
  logic                r_cmd_error;

  logic                w_sck_rise;
  logic                w_sck_fall;
  logic                w_sel_rise;
  logic                w_sel_fall;
  logic [IDX_BITS-1:0] w_addr_shift;
  logic [IDX_BITS-1:0] w_addr_inc;
  logic [7:0]          w_cmd_byte;

  qspi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_async   (bus.spi_clk_in),
    .o_rise    (w_sck_rise),
    .o_fall    (w_sck_fall)
  );

  qspi_sync_edge #(.RST_VAL(1'b1)) u_sel_sync (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_async   (bus.spi_select_n),
    .o_rise    (w_sel_rise),
    .o_fall    (w_sel_fall)
  );

  // Data pin synchroniser; same depth as the SCK path so a synced rise
  // pairs with the IO value present at the raw rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_io_meta <= 4'h0;
      r_io_sync <= 4'h0;
    end else begin
      r_io_meta <= bus.spi_data_in;
      r_io_sync <= r_io_meta;
    end
  end

  // Only the array-index bits of the wire address are kept; upper
  // nibbles simply shift out.
  assign w_addr_shift = IDX_BITS'({r_addr, r_io_sync});
  assign w_addr_inc   = r_addr + IDX_BITS'(1'b1);
  assign w_cmd_byte   = {r_hi, r_io_sync};

  // Frame decoder: state, nibble assembly, address and registered pin drive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= 8'd0;
      r_nib       <= 1'b0;
      r_rd_mode   <= 1'b0;
      r_hi        <= 4'h0;
      r_rd_byte   <= 8'h00;
      r_wr_byte   <= 8'h00;
      r_wr_pend   <= 1'b0;
      r_out       <= 4'h0;
      r_oe        <= 4'h0;
      r_active    <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_cmd_error <= 1'b0;
      r_wr_pend   <= 1'b0;
      // A select rise ends the frame from any state; IDLE then holds until
      // the next select fall, so the rise alone covers "select high".
      if (w_sel_rise) begin
        r_state  <= IDLE;
        r_out    <= 4'h0;
        r_oe     <= 4'h0;
        r_active <= 1'b0;
        r_nib    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_sel_fall) begin
              r_state <= CMD;
              r_cnt   <= 8'd0;
              r_nib   <= 1'b0;
            end
          end
          CMD: begin
            if (w_sck_rise) begin
              if (!r_nib) begin
                r_hi  <= r_io_sync;
                r_nib <= 1'b1;
              end else begin
                r_nib <= 1'b0;
                r_cnt <= 8'd0;
                if (w_cmd_byte == QSPI_CMD_QUAD_READ) begin
                  r_state   <= ADDR;
                  r_rd_mode <= 1'b1;
                  r_active  <= 1'b1;
                end else if (w_cmd_byte == QSPI_CMD_QUAD_WRITE) begin
                  r_state   <= ADDR;
                  r_rd_mode <= 1'b0;
                  r_active  <= 1'b1;
                end else begin
                  r_state     <= IGNORE;
                  r_cmd_error <= 1'b1;
                end
              end
            end
          end
          ADDR: begin
            if (w_sck_rise) begin
              r_addr <= w_addr_shift;
              if (r_cnt == LAST_ADDR_CNT) begin
                r_cnt <= 8'd0;
                if (!r_rd_mode) begin
                  r_state <= WR_DATA;
                end else if (DUMMY_CYCLES == 0) begin
                  r_rd_byte <= r_mem[w_addr_shift];
                  r_state   <= RD_DATA;
                  r_oe      <= 4'hF;
                end else begin
                  r_state <= DUMMY;
                end
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          DUMMY: begin
            if (w_sck_rise) begin
              if (r_cnt == LAST_DUMMY_CNT) begin
                r_rd_byte <= r_mem[r_addr];
                r_state   <= RD_DATA;
                r_oe      <= 4'hF;
                r_nib     <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          RD_DATA: begin
            if (w_sck_fall) begin
              r_out <= r_nib ? r_rd_byte[3:0] : r_rd_byte[7:4];
              r_nib <= ~r_nib;
            end else if (w_sck_rise && !r_nib) begin
              // Low nibble has just been sampled: advance and prefetch so
              // the next fall can drive the new high nibble.
              r_addr    <= w_addr_inc;
              r_rd_byte <= r_mem[w_addr_inc];
            end
          end
          WR_DATA: begin
            if (r_wr_pend) begin
              r_addr <= w_addr_inc;
            end
            if (w_sck_rise) begin
              if (!r_nib) begin
                r_hi  <= r_io_sync;
                r_nib <= 1'b1;
              end else begin
                r_wr_byte <= w_cmd_byte;
                r_wr_pend <= 1'b1;
                r_nib     <= 1'b0;
              end
            end
          end
          IGNORE: begin
            r_oe <= 4'h0;
          end
          default: begin
            r_state  <= IDLE;
            r_out    <= 4'h0;
            r_oe     <= 4'h0;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Array write port; contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (r_wr_pend) begin
      r_mem[r_addr] <= r_wr_byte;
    end
  end

  assign bus.spi_data_out = r_out;
  assign bus.spi_data_oe  = r_oe;
  assign bus.active       = r_active;
  assign bus.cmd_error    = r_cmd_error;

endmodule

// File: tb/tb_qspi_ram_target.sv
module tb_qspi_ram_target;
  import qspi_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   hp = 4;            // SCK half period in system clocks
  int   err_pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  qspi_ram_target_if bus();

  qspi_ram_target #(.DEPTH(256), .DUMMY_CYCLES(6), .ADDR_BITS(24)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: the initiator samples read data on SCK rise.
  always @(posedge bus.spi_clk_in) begin
    if (bus.spi_data_oe == 4'hF) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got nibble %h with oe=F, none expected", bus.spi_data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.spi_data_out !== mon_exp) begin
          errors++;
          $display("FAIL rd_nibble: got %h expected %h", bus.spi_data_out, mon_exp);
        end
      end
    end else if (bus.spi_data_oe !== 4'h0) begin
      checks++;
      errors++;
      $display("FAIL oe_value: got %h expected 0 or F", bus.spi_data_oe);
    end
  end

  // Count clocks with cmd_error high.
  always @(negedge clock) begin
    if (bus.cmd_error === 1'b1) err_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input logic [3:0] d);
    bus.spi_data_in = d;
    wait_clk(hp);
    bus.spi_clk_in = 1'b1;
    wait_clk(hp);
    bus.spi_clk_in = 1'b0;
  endtask

  task automatic rd_pulse(input logic [3:0] e);
    exp_q.push_back(e);
    pulse(4'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    bus.spi_select_n = 1'b0;
    send_byte(cmd);
    for (int i = QSPI_ADDR_NIBBLES - 1; i >= 0; i--) pulse(a[i*4 +: 4]);
  endtask

  task automatic frame_end(input int gap);
    bus.spi_select_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic write_frame(input logic [23:0] a, input logic [31:0] data, input int n, input int gap);
    logic [7:0] b;
    send_hdr(8'h38, a);
    for (int k = 0; k < n; k++) begin
      b = data[31 - 8*k -: 8];
      send_byte(b);
    end
    frame_end(gap);
  endtask

  task automatic read_frame(input logic [23:0] a, input logic [31:0] exp, input int n);
    logic [7:0] b;
    send_hdr(8'hEB, a);
    repeat (6) pulse(4'h0);
    for (int k = 0; k < n; k++) begin
      b = exp[31 - 8*k -: 8];
      rd_pulse(b[7:4]);
      rd_pulse(b[3:0]);
    end
    frame_end(6);
  endtask

  initial begin
    bus.spi_clk_in   = 1'b0;
    bus.spi_select_n = 1'b1;
    bus.spi_data_in  = 4'h0;
    wait_clk(3);
    check("reset_oe", {28'h0, bus.spi_data_oe}, 32'h0);
    check("reset_out", {28'h0, bus.spi_data_out}, 32'h0);
    check("reset_active", {31'h0, bus.active}, 32'h0);
    check("reset_cmd_error", {31'h0, bus.cmd_error}, 32'h0);
    reset = 1'b1;
    wait_clk(4);

    // Basic write then read back.
    send_hdr(8'h38, 24'h000010);
    send_byte(8'hA5);
    check("wr_active", {31'h0, bus.active}, 32'h1);
    check("wr_oe", {28'h0, bus.spi_data_oe}, 32'h0);
    send_byte(8'h3C);
    frame_end(6);
    check("idle_active", {31'h0, bus.active}, 32'h0);
    read_frame(24'h000010, 32'hA53C_0000, 2);

    // Address wrap at the top of the array.
    write_frame(24'h000001, 32'h5A00_0000, 1, 6);
    write_frame(24'h0000FF, 32'h1122_0000, 2, 6);
    read_frame(24'h0000FF, 32'h11225A00, 3);

    // Unknown command: one error pulse, no drive, array untouched.
    bus.spi_select_n = 1'b0;
    send_byte(8'h9F);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hFF);
    check("ign_active", {31'h0, bus.active}, 32'h0);
    check("ign_oe", {28'h0, bus.spi_data_oe}, 32'h0);
    check("ign_err_pulses", err_pulses, 32'd1);
    frame_end(6);
    read_frame(24'h000010, 32'hA53C_0000, 2);

    // Partial write: 1.5 bytes, only the first byte lands.
    write_frame(24'h000020, 32'h1234_0000, 2, 6);
    send_hdr(8'h38, 24'h000020);
    pulse(4'hC);
    pulse(4'hD);
    pulse(4'hE);
    frame_end(6);
    read_frame(24'h000020, 32'hCD34_0000, 2);

    // Back-to-back writes at SCK = clock/4 with 2 clocks of select high.
    hp = 2;
    write_frame(24'h000040, 32'h7788_0000, 2, 2);
    write_frame(24'h000042, 32'h9900_0000, 1, 6);
    hp = 4;
    read_frame(24'h000040, 32'h778899_00, 3);

    // Reset in the middle of read data.
    send_hdr(8'hEB, 24'h000010);
    repeat (6) pulse(4'h0);
    rd_pulse(4'hA);
    rd_pulse(4'h5);
    check("rd_active", {31'h0, bus.active}, 32'h1);
    check("rd_oe", {28'h0, bus.spi_data_oe}, 32'hF);
    reset = 1'b0;
    #1;
    check("rst_mid_oe", {28'h0, bus.spi_data_oe}, 32'h0);
    check("rst_mid_out", {28'h0, bus.spi_data_out}, 32'h0);
    check("rst_mid_active", {31'h0, bus.active}, 32'h0);
    bus.spi_select_n = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(4);
    read_frame(24'h000010, 32'hA53C_0000, 2);

    wait_clk(10);
    check("queue_drained", exp_q.size(), 32'd0);
    check("total_err_pulses", err_pulses, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
